aes_round_ctrl: RTL
===================

# aes_round_ctrl

Sequencing controller for the iterative AES encryption datapath (SubBytes/ShiftRows/MixColumns/AddRoundKey stage blocks plus round-key store). It accepts a block-start request with a key size, walks the datapath through the initial AddRoundKey, Nr-1 full rounds and the final round (no MixColumns), and drives one-hot stage enables, the round index for key selection, and a valid/ready output handshake. It supports 128/192/256-bit keys (Nr = 10/12/14).

## Interface
- No parameters; all constants come from the shared package.
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  request to encrypt the block currently presented to the datapath
- key_size  in  2  00=128, 01=192, 10=256, 11=reserved; sampled at acceptance
- in_ready  out  1  high only in IDLE; a request is accepted when start && in_ready
- load_en  out  1  datapath captures the input block (XORs it with round key 0)
- sbox_en  out  1  SubBytes step enable
- shiftrows_en  out  1  ShiftRows step enable
- mixcolumns_en  out  1  MixColumns step enable
- addrndkey_en  out  1  AddRoundKey step enable
- round  out  4  current round index 0..14, also the round-key select
- busy  out  1  high in every state except IDLE
- out_valid  out  1  state register holds the ciphertext
- out_ready  in  1  consumer accepts the ciphertext when out_valid && out_ready
- abort  in  1  present only with AES_CTRL_ABORT_EN

## Operation
- States: IDLE, INIT, SUB, SHIFT, MIX, ARK, DONE.
- IDLE: in_ready=1. On start && key_size != 11: latch Nr (10/12/14), round<=0, go to INIT. A start with key_size=11 is ignored: the FSM stays in IDLE and no enable pulses.
- INIT (1 cycle): load_en=1, addrndkey_en=1, round=0. Next state is SUB, with round<=1.
- SUB -> SHIFT -> MIX -> ARK for rounds 1..Nr-1. In the final round (round==Nr), SHIFT goes directly to ARK and MIX is skipped.
- ARK: if round==Nr, go to DONE. Otherwise round<=round+1 and go to SUB.
- Exactly one stage enable is high in each stage state. load_en pairs with addrndkey_en only in INIT. No enables are high in IDLE or DONE.
- DONE: out_valid=1, held stable until out_ready. Then go to IDLE; round holds Nr until the next acceptance.
- key_size changes after acceptance have no effect. start is ignored whenever in_ready=0, including the DONE cycle where out_ready is high.
- round never exceeds Nr. The width is 4 bits with no wrap.

## Timing
- Reset: state=IDLE, in_ready=1, round=0, busy=0, out_valid=0, all enables 0. The reset is synchronous, so the outputs reach these values at the first rising edge with rst_n=0.
- Reset mid-operation: the next state is IDLE and no out_valid is produced. Outputs are registered or pure functions of state and round.
- Acceptance edge T: INIT occupies cycle T+1, and the SUB of round r occupies T+2+4(r-1).
- Final round: SUB at T+4Nr-2, SHIFT at T+4Nr-1, ARK at T+4Nr.
- out_valid first rises at T+4Nr+1. That is T+41 for a 128-bit key, T+49 for 192 and T+57 for 256.
- Earliest next acceptance is 1 cycle after the out_ready handshake cycle (DONE -> IDLE -> accept).

## Configuration
- AES_CTRL_ABORT_EN defined: the abort port exists. abort=1 in any non-IDLE state forces IDLE next cycle: out_valid=0, enables 0, round=0, no ciphertext handshake. abort takes priority over out_ready and over state advancement. abort in IDLE has no effect and does not block a start in the same cycle.
- Not defined: the port is absent and the FSM only leaves DONE via out_ready or reset.

## Structure
- Shared package aes_pkg holds:
  - the state enum;
  - the key-size encodings KS_128/KS_192/KS_256;
  - the constants NR_128=10, NR_192=12, NR_256=14;
  - the function nr_of(key_size).
- One sub-module, aes_step_decode: combinational mapping from state (and round==0) to load_en and the four step enables, reused by the datapath testbench model.

## Test plan
- 128-bit request at edge T, out_ready=1 -> out_valid only at T+41. Also check:
  - 10 sbox_en pulses, 9 mixcolumns_en pulses, 11 addrndkey_en pulses;
  - round walks 0,1..10;
  - in_ready returns at T+42.
- 192 and 256-bit requests -> out_valid at T+49 and T+57; mixcolumns_en pulses 11 and 13 respectively; round peaks at 12 and 14.
- key_size=11 with start=1 -> FSM stays in IDLE, in_ready stays 1, no enable pulses over 20 cycles.
- Hold out_ready=0 for 5 cycles after DONE -> out_valid and round stay stable; start pulses during DONE are ignored; acceptance on out_ready -> IDLE the next cycle.
- rst_n=0 for one cycle during round 5 -> next cycle shows IDLE, all outputs at reset values; a new request then completes with normal latency.
- With AES_CTRL_ABORT_EN, abort in round 3 MIX -> IDLE next cycle with no out_valid. Also: abort and out_ready together in DONE -> IDLE and no handshake is counted.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared constants and types for the AES round sequencing controller.
// Optional abort input is enabled with AES_CTRL_ABORT_EN.
package aes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_SUB,
        ST_SHIFT,
        ST_MIX,
        ST_ARK,
        ST_DONE
    } state_e;

    localparam logic [1:0] KS_128  = 2'b00;
    localparam logic [1:0] KS_192  = 2'b01;
    localparam logic [1:0] KS_256  = 2'b10;
    localparam logic [1:0] KS_RSVD = 2'b11;

    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    // Reserved encoding maps to 0; callers never accept it.
    function automatic logic [3:0] nr_of(input logic [1:0] ks);
        logic [3:0] nr;
        nr = 4'd0;
        unique case (ks)
            KS_128:  nr = NR_128;
            KS_192:  nr = NR_192;
            KS_256:  nr = NR_256;
            default: nr = 4'd0;
        endcase
        return nr;
    endfunction

endpackage

// File: rtl/aes_step_decode.sv
// Maps the controller state onto load and datapath step enables.
// Shared with the datapath model so both agree on enable timing.
module aes_step_decode
    import aes_pkg::*;
(
    input  state_e state_i,
    input  logic   round_zero_i,
    output logic   load_en_o,
    output logic   sbox_en_o,
    output logic   shiftrows_en_o,
    output logic   mixcolumns_en_o,
    output logic   addrndkey_en_o
);

    always_comb begin
        load_en_o       = 1'b0;
        sbox_en_o       = 1'b0;
        shiftrows_en_o  = 1'b0;
        mixcolumns_en_o = 1'b0;
        addrndkey_en_o  = 1'b0;
        unique case (state_i)
            ST_INIT: begin
                load_en_o      = round_zero_i;
                addrndkey_en_o = 1'b1;
            end
            ST_SUB:   sbox_en_o       = 1'b1;
            ST_SHIFT: shiftrows_en_o  = 1'b1;
            ST_MIX:   mixcolumns_en_o = 1'b1;
            ST_ARK:   addrndkey_en_o  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/aes_round_ctrl.sv
// Round sequencer for the iterative AES encryption datapath.
// Define AES_CTRL_ABORT_EN to add the abort input.
module aes_round_ctrl
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] key_size,
    output logic       in_ready,
    output logic       load_en,
    output logic       sbox_en,
    output logic       shiftrows_en,
    output logic       mixcolumns_en,
    output logic       addrndkey_en,
    output logic [3:0] round,
    output logic       busy,
    output logic       out_valid,
`ifdef AES_CTRL_ABORT_EN
    input  logic       abort,
`endif
    input  logic       out_ready
);

    state_e     state_q, state_d;
    logic [3:0] round_q, round_d;
    logic [3:0] nr_q, nr_d;
    logic       in_ready_q;
    logic       busy_q;
    logic       out_valid_q;
    logic       last_round;

    assign last_round = (round_q == nr_q);

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        nr_d    = nr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start && key_size != KS_RSVD) begin
                    nr_d    = nr_of(key_size);
                    round_d = 4'd0;
                    state_d = ST_INIT;
                end
            end
            ST_INIT: begin
                round_d = 4'd1;
                state_d = ST_SUB;
            end
            ST_SUB:   state_d = ST_SHIFT;
            // Final round has no MixColumns.
            ST_SHIFT: state_d = last_round ? ST_ARK : ST_MIX;
            ST_MIX:   state_d = ST_ARK;
            ST_ARK: begin
                if (last_round) begin
                    state_d = ST_DONE;
                end else begin
                    round_d = round_q + 4'd1;
                    state_d = ST_SUB;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef AES_CTRL_ABORT_EN
        if (abort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            round_d = 4'd0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            round_q     <= 4'd0;
            nr_q        <= NR_128;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_q     <= round_d;
            nr_q        <= nr_d;
            in_ready_q  <= (state_d == ST_IDLE);
            busy_q      <= (state_d != ST_IDLE);
            out_valid_q <= (state_d == ST_DONE);
        end
    end

    aes_step_decode u_decode (
        .state_i         (state_q),
        .round_zero_i    (round_q == 4'd0),
        .load_en_o       (load_en),
        .sbox_en_o       (sbox_en),
        .shiftrows_en_o  (shiftrows_en),
        .mixcolumns_en_o (mixcolumns_en),
        .addrndkey_en_o  (addrndkey_en)
    );

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign round     = round_q;

endmodule
